// File: rtl/tx_pacer_pkg.sv
// Shared types and widths for the transmit sample pacer.
// The pacer pulls I/Q samples from the modulator and plays them to the DUC at a fixed rate.
package tx_pacer_pkg;

  localparam int SAMPLE_W = 48;
  localparam int HALF_W   = 24;
  localparam int UCOUNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } pacer_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [UCOUNT_W-1:0] sat_inc(input logic [UCOUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tx_iq_fifo.sv
// Synchronous DEPTH x 48-bit sample FIFO with flush.
// Pointers carry one extra bit so that full and empty can be told apart.
module tx_iq_fifo
  import tx_pacer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [SAMPLE_W-1:0]      wr_data,
  input  logic                     pop,
  output logic [SAMPLE_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                push_ok;
  logic                pop_ok;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == DEPTH_L);
  assign empty   = (wr_ptr == rd_ptr);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; only locations between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/tx_sample_pacer.sv
// Paces modulator I/Q samples out to the DUC, one every DIVIDE clocks, after a priming fill.
// Valid/ready: a sample transfers on any aclk edge where tvalid and tready are both high.
module tx_sample_pacer
  import tx_pacer_pkg::*;
#(
  parameter int DIVIDE = 640,
  parameter int DEPTH  = 8,
  parameter int PRIME  = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     tx_enable,
  input  logic [SAMPLE_W-1:0]      s_axis_txmod_tdata,
  input  logic                     s_axis_txmod_tvalid,
  output logic                     s_axis_txmod_tready,
  output logic [HALF_W-1:0]        dac_i,
  output logic [HALF_W-1:0]        dac_q,
  output logic                     sample_strobe,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [UCOUNT_W-1:0]      underflow_count,
  output logic                     running,
  output pacer_state_e             state_dbg
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDE - 1);
  localparam logic [LVL_W:0]   PRIME_L  = (LVL_W + 1)'(PRIME);

  pacer_state_e        state;
  pacer_state_e        state_next;
  logic [CNT_W-1:0]    tick_cnt;
  logic                tick;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] head;
  logic [LVL_W:0]      level_after_push;
  logic                prime_hit;

  assign s_axis_txmod_tready = tx_enable && (state != ST_IDLE) && !fifo_full;
  assign push      = s_axis_txmod_tvalid && s_axis_txmod_tready;
  assign tick      = (state == ST_RUN) && (tick_cnt == CNT_LAST);
  assign pop       = tick && tx_enable && !fifo_empty;
  assign running   = (state == ST_RUN);
  assign state_dbg = state;

  // Playout starts on the same edge that brings the level up to the prime mark.
  assign level_after_push = {1'b0, fifo_level} + (LVL_W + 1)'(push);
  assign prime_hit        = (level_after_push >= PRIME_L);

  tx_iq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .flush   (!tx_enable),
    .push    (push),
    .wr_data (s_axis_txmod_tdata),
    .pop     (pop),
    .rd_data (head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!tx_enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_PRIME;
        ST_PRIME: if (prime_hit) state_next = ST_RUN;
        ST_RUN:   state_next = ST_RUN;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tick_cnt        <= '0;
      dac_i           <= '0;
      dac_q           <= '0;
      sample_strobe   <= 1'b0;
      underflow_count <= '0;
    end else begin
      sample_strobe <= 1'b0;
      if (!tx_enable) begin
        tick_cnt <= '0;
        dac_i    <= '0;
        dac_q    <= '0;
      end else if (state == ST_RUN) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) begin
          sample_strobe <= 1'b1;
          if (fifo_empty) begin
            // Starved tick: play silence rather than repeating the last sample.
            dac_i           <= '0;
            dac_q           <= '0;
            underflow_count <= sat_inc(underflow_count);
          end else begin
            dac_i <= head[SAMPLE_W-1:HALF_W];
            dac_q <= head[HALF_W-1:0];
          end
        end
      end else begin
        tick_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tx_sample_pacer.sv
// Bench for tx_sample_pacer: directed phases with randomized traffic against a queue-based model.
// A second DIVIDE=1 instance runs alongside to push the underflow counter into saturation.
module tb_tx_sample_pacer;
  import tx_pacer_pkg::*;

  localparam int DIVIDE = 640;
  localparam int DEPTH  = 8;
  localparam int PRIME  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic                 aclk;
  logic                 aresetn;
  logic                 tx_enable;
  logic [SAMPLE_W-1:0]  s_axis_txmod_tdata;
  logic                 s_axis_txmod_tvalid;
  logic                 s_axis_txmod_tready;
  logic [HALF_W-1:0]    dac_i;
  logic [HALF_W-1:0]    dac_q;
  logic                 sample_strobe;
  logic [LVL_W-1:0]     fifo_level;
  logic [UCOUNT_W-1:0]  underflow_count;
  logic                 running;
  pacer_state_e         state_dbg;

  logic                 sat_rstn;
  logic                 sat_en;
  logic [SAMPLE_W-1:0]  sat_data;
  logic                 sat_valid;
  logic                 sat_tready;
  logic [HALF_W-1:0]    sat_i;
  logic [HALF_W-1:0]    sat_q;
  logic                 sat_strobe;
  logic [LVL_W-1:0]     sat_level;
  logic [UCOUNT_W-1:0]  sat_uf;
  logic                 sat_running;
  pacer_state_e         sat_state;

  tx_sample_pacer #(.DIVIDE(DIVIDE), .DEPTH(DEPTH), .PRIME(PRIME)) u_dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .tx_enable           (tx_enable),
    .s_axis_txmod_tdata  (s_axis_txmod_tdata),
    .s_axis_txmod_tvalid (s_axis_txmod_tvalid),
    .s_axis_txmod_tready (s_axis_txmod_tready),
    .dac_i               (dac_i),
    .dac_q               (dac_q),
    .sample_strobe       (sample_strobe),
    .fifo_level          (fifo_level),
    .underflow_count     (underflow_count),
    .running             (running),
    .state_dbg           (state_dbg)
  );

  tx_sample_pacer #(.DIVIDE(1), .DEPTH(DEPTH), .PRIME(PRIME)) u_sat (
    .aclk                (aclk),
    .aresetn             (sat_rstn),
    .tx_enable           (sat_en),
    .s_axis_txmod_tdata  (sat_data),
    .s_axis_txmod_tvalid (sat_valid),
    .s_axis_txmod_tready (sat_tready),
    .dac_i               (sat_i),
    .dac_q               (sat_q),
    .sample_strobe       (sat_strobe),
    .fifo_level          (sat_level),
    .underflow_count     (sat_uf),
    .running             (sat_running),
    .state_dbg           (sat_state)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // reference model: the FIFO is a queue, the tick is a phase count since RUN entry
  logic [SAMPLE_W-1:0] exp_q[$];
  pacer_state_e        m_state;
  int                  m_phase;
  logic [HALF_W-1:0]   m_i;
  logic [HALF_W-1:0]   m_qv;
  logic                m_strobe;
  int                  m_uf;

  int cyc = 0;
  int prev_strobe = -1;
  bit period_on = 1'b0;

  bit seq_mode = 1'b1;
  int seq_k = 0;
  int valid_permille = 0;
  int push_budget = -1;

  int sat_pushed = 0;
  int sat_strobes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_state  = ST_IDLE;
    m_phase  = 0;
    m_i      = '0;
    m_qv     = '0;
    m_strobe = 1'b0;
    m_uf     = 0;
  endtask

  function automatic bit model_tready(input bit en);
    return en && (m_state != ST_IDLE) && (exp_q.size() < DEPTH);
  endfunction

  task automatic model_edge(input bit acc, input bit en, input logic [SAMPLE_W-1:0] din);
    bit tk;
    bit was_empty;
    logic [SAMPLE_W-1:0] s;
    m_strobe = 1'b0;
    if (!en) begin
      exp_q.delete();
      m_state = ST_IDLE;
      m_phase = 0;
      m_i     = '0;
      m_qv    = '0;
    end else begin
      case (m_state)
        ST_IDLE: m_state = ST_PRIME;
        ST_PRIME: begin
          if (acc) exp_q.push_back(din);
          if (exp_q.size() >= PRIME) begin
            m_state = ST_RUN;
            m_phase = 0;
          end
        end
        default: begin
          tk        = (m_phase == DIVIDE - 1);
          m_phase   = tk ? 0 : m_phase + 1;
          was_empty = (exp_q.size() == 0);
          if (tk && !was_empty) begin
            s    = exp_q.pop_front();
            m_i  = s[47:24];
            m_qv = s[23:0];
          end
          if (acc) exp_q.push_back(din);
          if (tk && was_empty) begin
            m_i  = '0;
            m_qv = '0;
            if (m_uf < 65535) m_uf++;
          end
          m_strobe = tk;
        end
      endcase
    end
  endtask

  // driver tasks
  task automatic next_sample();
    logic [31:0] a;
    logic [31:0] b;
    if (seq_mode) begin
      s_axis_txmod_tdata = {24'(2 * seq_k + 1), 24'(2 * seq_k + 2)};
      seq_k++;
    end else begin
      a = $urandom;
      b = $urandom;
      s_axis_txmod_tdata = {a[15:0], b};
    end
  endtask

  task automatic step();
    bit acc;
    bit sacc;
    bit en;
    logic [SAMPLE_W-1:0] din;
    en   = tx_enable;
    din  = s_axis_txmod_tdata;
    acc  = s_axis_txmod_tvalid && model_tready(en);
    sacc = sat_valid && sat_tready;
    @(posedge aclk);
    model_edge(acc, en, din);
    cyc++;
    #1;
    chk("tready",  64'(s_axis_txmod_tready), 64'(model_tready(tx_enable)));
    chk("level",   64'(fifo_level),          64'(exp_q.size()));
    chk("state",   64'(state_dbg),           64'(m_state));
    chk("running", 64'(running),             64'(m_state == ST_RUN));
    chk("dac_i",   64'(dac_i),               64'(m_i));
    chk("dac_q",   64'(dac_q),               64'(m_qv));
    chk("strobe",  64'(sample_strobe),       64'(m_strobe));
    chk("uflow",   64'(underflow_count),     64'(m_uf));
    if (sample_strobe) begin
      if (period_on && prev_strobe >= 0) chk("period", 64'(cyc - prev_strobe), 64'(DIVIDE));
      prev_strobe = cyc;
    end
    if (acc) begin
      if (push_budget > 0) push_budget--;
      next_sample();
    end
    if (push_budget == 0) s_axis_txmod_tvalid = 1'b0;
    else if (!s_axis_txmod_tvalid || acc)
      s_axis_txmod_tvalid = ($urandom_range(0, 999) < valid_permille);
    if (sacc) begin
      sat_pushed++;
      sat_data = sat_data + 48'h000001_000001;
    end
    if (sat_pushed >= PRIME) sat_valid = 1'b0;
    if (sat_strobe) sat_strobes++;
  endtask

  task automatic wait_strobes(input int n, input string tag);
    int seen;
    int budget;
    seen   = 0;
    budget = n * (DIVIDE + 8) + 16;
    while (seen < n && budget > 0) begin
      step();
      budget--;
      if (sample_strobe) seen++;
    end
    chk({tag, "_strobes"}, 64'(seen), 64'(n));
  endtask

  task automatic wait_running(input string tag);
    int budget;
    budget = 200;
    while (!running && budget > 0) begin
      step();
      budget--;
    end
    chk({tag, "_running"}, 64'(running), 64'(1));
  endtask

  task automatic wait_level(input int lvl, input int budget_in, input string tag);
    int budget;
    budget = budget_in;
    while (fifo_level != LVL_W'(lvl) && budget > 0) begin
      step();
      budget--;
    end
    chk({tag, "_level"}, 64'(fifo_level), 64'(lvl));
  endtask

  initial begin
    int run_cyc;
    int uf0;
    int cnt;

    aresetn = 1'b0;
    sat_rstn = 1'b0;
    tx_enable = 1'b0;
    s_axis_txmod_tvalid = 1'b0;
    s_axis_txmod_tdata = '0;
    sat_en = 1'b0;
    sat_valid = 1'b0;
    sat_data = 48'h000010_000020;
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tready",  64'(s_axis_txmod_tready), 64'(0));
    chk("rst_level",   64'(fifo_level),          64'(0));
    chk("rst_running", 64'(running),             64'(0));
    chk("rst_dac",     64'({dac_i, dac_q}),      64'(0));
    chk("rst_strobe",  64'(sample_strobe),       64'(0));
    chk("rst_uflow",   64'(underflow_count),     64'(0));
    @(negedge aclk);
    aresetn  = 1'b1;
    sat_rstn = 1'b1;

    // idle with enable low: nothing moves
    repeat (5) step();

    // prime: always-valid counting samples
    sat_en = 1'b1;
    sat_valid = 1'b1;
    seq_mode = 1'b1;
    seq_k = 0;
    next_sample();
    valid_permille = 1000;
    tx_enable = 1'b1;
    s_axis_txmod_tvalid = 1'b1;
    wait_running("prime");
    run_cyc = cyc;
    chk("prime_level_at_run", 64'(fifo_level), 64'(PRIME));
    wait_level(DEPTH, 50, "prime_fill");
    chk("tready_full", 64'(s_axis_txmod_tready), 64'(0));
    wait_strobes(1, "first");
    chk("first_delay", 64'(cyc - run_cyc), 64'(DIVIDE));
    chk("first_dac_i", 64'(dac_i), 64'(1));
    chk("first_dac_q", 64'(dac_q), 64'(2));

    // steady rate with continuous supply
    period_on = 1'b1;
    wait_strobes(15, "steady");
    chk("steady_uflow", 64'(underflow_count), 64'(0));

    // random data, bursty then sparse supply
    seq_mode = 1'b0;
    valid_permille = 500;
    wait_strobes(5, "bursty");
    valid_permille = 1;
    wait_strobes(8, "sparse");

    // disable with five samples queued
    valid_permille = 1000;
    s_axis_txmod_tvalid = 1'b1;
    wait_level(DEPTH, 2 * DIVIDE, "refill");
    valid_permille = 0;
    s_axis_txmod_tvalid = 1'b0;
    wait_level(5, 4 * DIVIDE, "drain");
    uf0 = m_uf;
    period_on = 1'b0;
    prev_strobe = -1;
    tx_enable = 1'b0;
    step();
    chk("dis_running", 64'(running), 64'(0));
    chk("dis_level",   64'(fifo_level), 64'(0));
    chk("dis_dac",     64'({dac_i, dac_q}), 64'(0));
    chk("dis_uflow",   64'(underflow_count), 64'(uf0));
    cnt = 0;
    repeat (1500) begin
      step();
      if (sample_strobe) cnt++;
    end
    chk("dis_no_strobe", 64'(cnt), 64'(0));

    // re-enable re-primes
    tx_enable = 1'b1;
    valid_permille = 1000;
    s_axis_txmod_tvalid = 1'b1;
    wait_running("reprime");
    period_on = 1'b1;
    wait_strobes(3, "reprime");

    // starvation: exactly PRIME samples then nothing
    period_on = 1'b0;
    prev_strobe = -1;
    tx_enable = 1'b0;
    step();
    seq_mode = 1'b1;
    seq_k = 100;
    next_sample();
    push_budget = PRIME;
    tx_enable = 1'b1;
    s_axis_txmod_tvalid = 1'b1;
    wait_running("starve");
    period_on = 1'b1;
    uf0 = m_uf;
    wait_strobes(2 * PRIME, "starve");
    chk("starve_uf_delta", 64'(underflow_count - UCOUNT_W'(uf0)), 64'(PRIME));
    chk("starve_dac_zero", 64'({dac_i, dac_q}), 64'(0));
    push_budget = -1;

    // asynchronous reset between edges while running
    repeat (7) step();
    #3;
    aresetn = 1'b0;
    #1;
    chk("arst_dac",     64'({dac_i, dac_q}), 64'(0));
    chk("arst_strobe",  64'(sample_strobe), 64'(0));
    chk("arst_uflow",   64'(underflow_count), 64'(0));
    chk("arst_running", 64'(running), 64'(0));
    chk("arst_level",   64'(fifo_level), 64'(0));
    chk("arst_tready",  64'(s_axis_txmod_tready), 64'(0));
    model_reset();
    period_on = 1'b0;
    prev_strobe = -1;
    #1;
    aresetn = 1'b1;
    tx_enable = 1'b0;
    repeat (4) step();

    // let the DIVIDE=1 instance accumulate at least 70000 starved ticks
    while (sat_strobes < 70000 + PRIME && cyc < 90000) step();
    chk("sat_ticks", 64'(sat_strobes >= 70000 + PRIME), 64'(1));
    chk("sat_uflow", 64'(sat_uf), 64'(16'hFFFF));
    chk("sat_running", 64'(sat_running), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
